// File: rtl/uart_serial_core.sv
// 8N1 UART transmitter/receiver pair with independent TX and RX paths.
// Define UART_TX_FIFO_EN to place a TX_FIFO_DEPTH-entry FIFO in front of the serializer.
module uart_serial_core #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_busy,
    input  logic       rx_re,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       txd,
    input  logic       rxd
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (CLKS_PER_BIT < 8 || TX_FIFO_DEPTH < 2 ||
        (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_serial_core: illegal CLKS_PER_BIT or TX_FIFO_DEPTH");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tx_load;
    logic [7:0]       tx_load_byte;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0] fifo_mem_q [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic fifo_empty, fifo_full, fifo_push;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_push    = tx_we && !fifo_full;
    assign tx_load      = (tx_state_q == TX_IDLE) && !fifo_empty;
    assign tx_load_byte = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign tx_busy      = fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (tx_load)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end
`else
    assign tx_load      = tx_we && (tx_state_q == TX_IDLE);
    assign tx_load_byte = tx_data;
    assign tx_busy      = (tx_state_q != TX_IDLE);
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: if (tx_load) begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_shift_d = tx_load_byte;
            end
            TX_START: if (tx_cnt_q == BIT_LAST) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
            end else tx_cnt_d = tx_cnt_q + CNT_ONE;
            TX_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
                else                  tx_idx_d   = tx_idx_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q + CNT_ONE;
            TX_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
            end else tx_cnt_d = tx_cnt_q + CNT_ONE;
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the state being entered so txd stays a clean flop output.
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign txd = txd_q;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             rx_accept;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_accept    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + CNT_ONE;
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_idx_d   = rx_idx_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q + CNT_ONE;
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                rx_accept  = rx_sync_q;
            end else rx_cnt_d = rx_cnt_q + CNT_ONE;
            default: rx_state_d = RX_IDLE;
        endcase

        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_re && rx_valid_q) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end
        // A new byte always wins; it only counts as overrun if nobody read the old one.
        if (rx_accept) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_re) rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_meta_q    <= rxd;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
endmodule

// File: tb/tb_uart_serial_core.sv
// Self-checking bench for uart_serial_core at 16 clocks per bit; TX and RX bytes are
// tracked through expected-byte queues and checked as frames complete.
module tb_uart_serial_core;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_we = 1'b0;
    logic       tx_busy;
    logic       rx_re = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       txd;
    logic       rxd = 1'b1;

    int total = 0;
    int bad   = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    uart_serial_core #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
        .rx_re(rx_re), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    // Driver: one-cycle write strobe, entered and left on a falling edge.
    task automatic tx_write(input logic [7:0] b, input bit expect_sent);
        tx_data = b;
        tx_we   = 1'b1;
        if (expect_sent) tx_exp_q.push_back(b);
        @(negedge clk);
        tx_we = 1'b0;
    endtask

    // Monitor: find a start bit, sample each bit mid-way, compare against the queue head.
    task automatic tx_check_frame(input string name);
        int waited;
        logic [7:0] got;
        logic [7:0] exp;
        logic stop_bit;
        waited = 0;
        while (txd !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (txd !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s: no start bit, txd=%b want 0", name, txd);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            got[b] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = txd;
        total++;
        if (tx_exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected frame %02h", name, got);
        end else begin
            exp = tx_exp_q.pop_front();
            if (got !== exp || stop_bit !== 1'b1) begin
                bad++;
                $display("FAIL %s: byte=%02h stop=%b, want %02h stop=1", name, got, stop_bit, exp);
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (stop_ok) rx_exp_q.push_back(b);
    endtask

    task automatic rx_expect_byte(input string name);
        int waited;
        logic [7:0] exp;
        waited = 0;
        while (rx_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (rx_exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no byte expected, rx_data=%02h", name, rx_data);
        end else begin
            exp = rx_exp_q.pop_front();
            if (rx_valid !== 1'b1 || rx_data !== exp) begin
                bad++;
                $display("FAIL %s: rx_valid=%b rx_data=%02h, want 1/%02h", name, rx_valid, rx_data, exp);
            end
        end
    endtask

    task automatic rx_read();
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (txd !== 1'b1)        begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (tx_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        total++; if (rx_data !== 8'h00)   begin bad++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_tx_basic();
        logic [7:0] bv;
        logic exp_bit;
        int errs;
        int busy_cnt;
        bv = 8'h55;
        errs = 0;
        busy_cnt = 0;
        tx_write(bv, 1'b0);
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB)            exp_bit = 1'b0;
            else if (i >= 9 * CPB)  exp_bit = 1'b1;
            else                    exp_bit = bv[(i / CPB) - 1];
            if (txd !== exp_bit) errs++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (i == 50) begin
                tx_data = 8'hFF;
                tx_we   = 1'b1;
            end else tx_we = 1'b0;
            @(negedge clk);
        end
        total++; if (errs != 0)      begin bad++; $display("FAIL tx_wave: %0d wrong bit cycles, want 0", errs); end
        total++; if (busy_cnt != 160) begin bad++; $display("FAIL tx_busy_len: got %0d want 160", busy_cnt); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_end: got %b want 0", tx_busy); end
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL tx_dropped_write: %0d non-idle cycles, want 0", errs); end
    endtask
`else
    task automatic test_fifo();
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    if (k == 9) begin
                        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL fifo_busy_9: got %b want 0", tx_busy); end
                    end
                    if (k == 10) begin
                        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL fifo_busy_10: got %b want 1", tx_busy); end
                    end
                    tx_data = 8'(k);
                    tx_we   = 1'b1;
                    if (k <= 9) tx_exp_q.push_back(8'(k));
                    @(negedge clk);
                end
                tx_we = 1'b0;
            end
            begin
                for (int f = 0; f < 9; f++) tx_check_frame("fifo_order");
            end
        join
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 3 * CPB; i++) begin
                if (txd !== 1'b1) errs++;
                @(negedge clk);
            end
            total++; if (errs != 0) begin bad++; $display("FAIL fifo_dropped: %0d low cycles after last frame, want 0", errs); end
        end
    endtask
`endif

    task automatic test_rx_basic();
        rx_send(8'hA3, 1'b1);
        rx_expect_byte("rx_a3");
        rx_read();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_read_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'hA3) begin bad++; $display("FAIL rx_read_hold: got %02h want a3", rx_data); end
    endtask

    task automatic test_rx_glitch();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_glitch: rx_valid=%b want 0", rx_valid); end
        rx_send(8'h5A, 1'b1);
        rx_expect_byte("rx_after_glitch");
        rx_read();
    endtask

    task automatic test_rx_framing();
        rx_send(8'h77, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_frame_err_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rx_frame_err_data: got %02h want 5a", rx_data); end
    endtask

    task automatic test_rx_overrun();
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        // The first byte is overwritten; only the newest one remains observable.
        while (rx_exp_q.size() > 1) void'(rx_exp_q.pop_front());
        rx_expect_byte("rx_overwrite");
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL rx_overrun_set: got %b want 1", rx_overrun); end
        rx_read();
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL rx_overrun_read_valid: got %b want 0", rx_valid); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL rx_overrun_clear: got %b want 0", rx_overrun); end
    endtask

    task automatic test_back_to_back();
        int waited;
        tx_write(8'h96, 1'b1);
        tx_check_frame("b2b_first");
        waited = 0;
        while (tx_busy !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: tx_busy=%b want 0", tx_busy); end
        tx_write(8'h69, 1'b1);
        tx_check_frame("b2b_second");
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_duplex();
        fork
            begin
                tx_write(8'hC5, 1'b1);
                tx_check_frame("duplex_tx");
            end
            rx_send(8'h3A, 1'b1);
        join
        rx_expect_byte("duplex_rx");
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        tx_write(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (txd !== 1'b1)      begin bad++; $display("FAIL rst_mid_txd: got %b want 1", txd); end
        total++; if (tx_busy !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx_data: got %02h want 00", rx_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_write(8'h3C, 1'b1);
        tx_check_frame("post_reset_tx");
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifndef UART_TX_FIFO_EN
        test_tx_basic();
`else
        test_fifo();
`endif
        test_rx_basic();
        test_rx_glitch();
        test_rx_framing();
        test_rx_overrun();
        test_back_to_back();
        test_duplex();
        test_reset_mid_frame();
        total++;
        if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: tx=%0d rx=%0d, want 0/0", tx_exp_q.size(), rx_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_serial_core.md
UART_SERIAL_CORE -- requirements
Module: uart_serial_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per bit (100 MHz / 115200 baud); minimum 8.
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 8, TX FIFO entries; power of two; used only with UART_TX_FIFO_EN.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, sampled when tx_we=1.
REQ-006 SHALL have port tx_we  input  1  one-cycle write strobe from the MMIO memory stage.
REQ-007 SHALL have port tx_busy  output  1  transmitter cannot accept a byte.
REQ-008 SHALL have port rx_re  input  1  receive-read strobe from the MMIO memory stage (combinational on its side).
REQ-009 SHALL have port rx_data  output  8  last received byte.
REQ-010 SHALL have port rx_valid  output  1  unread byte in rx_data.
REQ-011 SHALL have port rx_overrun  output  1  sticky: unread byte was overwritten.
REQ-012 SHALL have port txd  output  1  serial out, idle high.
REQ-013 SHALL have port rxd  input  1  serial in, asynchronous to clk.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_STOP; TX_IDLE->TX_START on load, TX_DATA runs a 3-bit index 0..7, TX_STOP->TX_IDLE after its full bit time.
REQ-016 txd SHALL be registered: 1 in TX_IDLE and TX_STOP, 0 in TX_START, shift-register bit 0 in TX_DATA.
REQ-017 Without FIFO: tx_we while TX_IDLE SHALL load tx_data; txd=0 and tx_busy=1 from the next cycle; tx_busy=0 on the cycle TX_IDLE is re-entered; 10*CLKS_PER_BIT busy cycles per byte.
REQ-018 tx_we while tx_busy=1 SHALL be dropped without state change.
REQ-019 rxd SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-020 RX FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP; synchronized falling edge in RX_IDLE -> RX_START.
REQ-021 RX_START SHALL resample at CLKS_PER_BIT/2; if high, return to RX_IDLE (glitch reject); else sample each data bit and the stop bit at one CLKS_PER_BIT intervals thereafter.
REQ-022 Stop sample 1: rx_data<=byte and rx_valid<=1 on the same edge; stop sample 0 (framing error): byte discarded, outputs unchanged; both return to RX_IDLE.
REQ-023 rx_re with rx_valid=1 SHALL clear rx_valid and rx_overrun on the next edge; rx_data SHALL hold until the next accepted byte, so the consumer's registered read the cycle after rx_re sees the same byte.
REQ-024 Byte accepted while rx_valid=1 and rx_re=0: overwrite rx_data, set rx_overrun.
REQ-025 Byte accepted on the same cycle as rx_re: new byte wins; rx_valid stays 1, rx_overrun cleared.
REQ-026 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-027 rst=1 SHALL immediately force txd=1, tx_busy=0, rx_data=0x00, rx_valid=0, rx_overrun=0, both FSMs idle, counters 0, FIFO empty.
REQ-028 Reset mid-frame SHALL abort the frame; after release the first new tx_we starts a clean frame, and RX waits for a fresh falling edge.

Configuration
REQ-029 Macro UART_TX_FIFO_EN defined: TX_FIFO_DEPTH-entry FIFO between tx_we and the serializer; tx_we pushes when not full; serializer pops the head one cycle after it is idle with FIFO non-empty; tx_busy = FIFO full; bytes sent in write order.
REQ-030 Macro undefined: no FIFO, behaviour per REQ-017/018 exactly.

Verification (CLKS_PER_BIT=16)
REQ-031 No FIFO, tx_we with 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 16 cycles; tx_busy high 160 cycles; second tx_we at cycle 50 dropped.
REQ-032 Drive rxd frame 0xA3 -> rx_valid=1, rx_data=0xA3 after stop sample; rx_re pulse -> rx_valid=0 next cycle, rx_data still 0xA3.
REQ-033 rxd low for 4 cycles then high -> no rx_valid, RX returns to RX_IDLE.
REQ-034 Frames 0x11 then 0x22, no rx_re -> rx_data=0x22, rx_overrun=1; rx_re clears rx_valid and rx_overrun.
REQ-035 UART_TX_FIFO_EN, writes 0x01..0x0A on 10 consecutive cycles -> tx_busy=1 on 10th, 0x0A dropped, 0x01..0x09 appear on txd in order.
REQ-036 rst asserted in TX_DATA of 0x00 -> txd=1 same cycle, tx_busy=0; post-reset write 0x3C transmits correctly.
